// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the four-input round-robin scheduler
package arb_pkg;

    localparam int NUM_FIFOS = 4;
    localparam int PTR_W     = 2;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_grant4.sv
// rtl/rr_grant4.sv - rotate-priority encoder: first requester after last, wrapping
module rr_grant4
    import arb_pkg::*;
(
    input  logic [NUM_FIFOS-1:0] req,
    input  ptr_t                 last,
    output logic [NUM_FIFOS-1:0] gnt,
    output ptr_t                 idx,
    output logic                 found
);

    ptr_t cand;

    // Walk last+1 .. last+4 (mod 4); the first requester wins, so last itself has lowest priority
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_FIFOS; k++) begin
            cand = last + ptr_t'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_4a1.sv
// rtl/arbitro_rr_4a1.sv - drains four class FIFOs into one destination FIFO, optional ARB_BURST_EN
module arbitro_rr_4a1
    import arb_pkg::*;
#(
    parameter int WORD_SIZE = 12,
    parameter int BURST_LEN = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_FIFOS*WORD_SIZE-1:0] data_in_arb,
    input  logic [NUM_FIFOS-1:0]           fifos_empty,
    input  logic                           fifo_almost_full,
    output logic [NUM_FIFOS-1:0]           pop,
    output logic                           push,
    output logic [WORD_SIZE-1:0]           data_out_arb,
    output logic                           idle
);

    arb_state_t           state;
    arb_state_t           state_nx;
    ptr_t                 last;
    ptr_t                 sel_q;
    ptr_t                 grant_idx;
    logic                 grant_found;
    logic [NUM_FIFOS-1:0] grant_vec;
    logic [NUM_FIFOS-1:0] req;
    logic [NUM_FIFOS-1:0] rr_gnt;
    ptr_t                 rr_idx;
    logic                 rr_found;
    logic                 push_q;
    logic [WORD_SIZE-1:0] slice;
    logic [WORD_SIZE-1:0] hold_q;
    logic                 any_req;
    logic                 all_empty;

    assign req       = ~fifos_empty;
    assign any_req   = |req;
    assign all_empty = &fifos_empty;

    rr_grant4 u_rr_grant4 (
        .req   (req),
        .last  (last),
        .gnt   (rr_gnt),
        .idx   (rr_idx),
        .found (rr_found)
    );

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic [CNT_W-1:0] burst_cnt;
    logic             burst_hold;

    // The current grantee keeps the grant while it has pops left in its burst and is still nonempty
    always_comb begin
        burst_hold = (burst_cnt != '0) && (burst_cnt < CNT_W'(BURST_LEN)) && req[last];
        if (burst_hold) begin
            grant_vec   = '0;
            grant_vec[last] = 1'b1;
            grant_idx   = last;
            grant_found = 1'b1;
        end else begin
            grant_vec   = rr_gnt;
            grant_idx   = rr_idx;
            grant_found = rr_found;
        end
    end

    // Count consecutive pops of one grantee; any cycle without a pop (stall or drained) restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (|pop) begin
            burst_cnt <= burst_hold ? burst_cnt + CNT_W'(1) : CNT_W'(1);
        end else begin
            burst_cnt <= '0;
        end
    end
`else
    logic unused_burst_len;
    assign unused_burst_len = ^BURST_LEN;

    // Strict round robin: one pop per grantee before moving on
    always_comb begin
        grant_vec   = rr_gnt;
        grant_idx   = rr_idx;
        grant_found = rr_found;
    end
`endif

    // Pop is combinational so a FIFO emptying this cycle is never popped; almost_full blocks it outright
    always_comb begin
        pop = '0;
        if (reset && grant_found && !fifo_almost_full) begin
            pop = grant_vec;
        end
    end

    // The pointer moves only on an actual pop, so it stays put while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= ptr_t'(NUM_FIFOS - 1);
        end else if (|pop) begin
            last <= grant_idx;
        end
    end

    // Remember which FIFO was popped; its read data arrives one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            push_q <= |pop;
            if (|pop) begin
                sel_q <= grant_idx;
            end
        end
    end

    // Select the read data of the FIFO popped last cycle
    always_comb begin
        slice = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (sel_q == ptr_t'(i)) begin
                slice = data_in_arb[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Keep the last pushed word so the output holds steady between pushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (push_q) begin
            hold_q <= slice;
        end
    end

    assign push         = push_q;
    assign data_out_arb = push_q ? slice : hold_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: drained sources win over backpressure; all-empty implies no pop, so nothing is pending
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = fifo_almost_full ? STALL : ACTIVE;
                end
            end
            ACTIVE: begin
                if (all_empty) begin
                    state_nx = IDLE;
                end else if (fifo_almost_full) begin
                    state_nx = STALL;
                end
            end
            STALL: begin
                if (all_empty) begin
                    state_nx = IDLE;
                end else if (!fifo_almost_full) begin
                    state_nx = ACTIVE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign idle = (state == IDLE);

endmodule

// File: doc/arbitro_rr_4a1.md
Name: arbitro_rr_4a1

Overview:
- Round-robin scheduler that drains four class FIFOs into one shared downstream FIFO.
- It sits on the opposite side of the class-demux arbiter: it takes the four per-class FIFOs, pops at most one per cycle and pushes the word into the single destination FIFO.
- It honours destination almost_full backpressure.
- A small FSM tracks idle, active and stalled operation for the top-level controller.

Parameters:
- WORD_SIZE, 12, width of one data word.
- BURST_LEN, 2, max consecutive grants to one FIFO; used only when ARB_BURST_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- data_in_arb  input  4*WORD_SIZE  read data of FIFO i in bits [i*WORD_SIZE +: WORD_SIZE]; valid the cycle after its pop.
- fifos_empty  input  4  empty flag per source FIFO.
- fifo_almost_full  input  1  almost_full of the destination FIFO.
- pop  output  4  one-hot (or zero) pop to source FIFOs; combinational.
- push  output  1  push to destination FIFO; registered.
- data_out_arb  output  WORD_SIZE  word pushed; valid when push=1.
- idle  output  1  1 when FSM is in IDLE and nothing is in flight.

Behaviour:
- Reset (reset=0, async):
  - pop=0, push=0, data_out_arb=0, idle=1, state=IDLE.
  - Round-robin pointer last=3, so the first grant goes to FIFO 0.
  - Any in-flight word is discarded.
- FSM states: IDLE, ACTIVE, STALL.
  - IDLE -> ACTIVE: any fifos_empty[i]=0 and fifo_almost_full=0.
  - IDLE -> STALL: any nonempty and fifo_almost_full=1.
  - ACTIVE -> STALL: fifo_almost_full=1.
  - STALL -> ACTIVE: fifo_almost_full=0 and any nonempty.
  - ACTIVE or STALL -> IDLE: all four empty, fifo_almost_full irrelevant, and no push pending in the next cycle.
  - idle = (state==IDLE).
- Grant:
  - Search order is last+1, last+2, last+3, last (mod 4); grant the first FIFO with fifos_empty=0.
  - pop[g]=1 in the same cycle when that search finds a FIFO and fifo_almost_full=0, whatever the state. An empty FIFO is never popped.
  - On a pop, last<=g at the clock edge.
- Datapath, 1-cycle latency:
  - Cycle n: pop[g]=1.
  - Cycle n+1: push=1 and data_out_arb = data_in_arb slice g, using the registered select g.
  - Throughput is one word per cycle while sources are nonempty and the destination is not almost_full.
- Backpressure:
  - fifo_almost_full=1 blocks new pops that same cycle.
  - A pop issued in cycle n still pushes in n+1 even if almost_full rises in n+1. The destination FIFO's almost_full threshold leaves at least 1 free slot.
- Simultaneous events:
  - A FIFO going empty in the same cycle as its grant is handled by sampling fifos_empty combinationally.
  - The round-robin pointer does not advance while stalled.
- data_out_arb holds its last value when push=0.

Optional Feature:
- ARB_BURST_EN defined:
  - A burst counter lets the current grantee keep the grant for up to BURST_LEN consecutive pops while it stays nonempty.
  - The grant then moves on by round robin.
  - The counter resets to 0 when the grant changes, on stall, or on reset.
- ARB_BURST_EN undefined: strict 1-pop round robin, no burst counter logic present.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding IDLE=2'd0, ACTIVE=2'd1, STALL=2'd2;
  - NUM_FIFOS=4;
  - pointer width 2.
- One natural sub-module, rr_grant4: combinational rotate-priority encoder. Inputs: request vector and last pointer. Outputs: one-hot grant and 2-bit index. It is shared with future arbiters.

Test Plan:
- Reset: hold reset=0 with all FIFOs nonempty -> pop=0, push=0, idle=1, data_out_arb=0. Release reset -> first pop=4'b0001.
- Fairness: all four nonempty with data 0x00A/0x10B/0x20C/0x30D, almost_full=0 -> pops 0001, 0010, 0100, 1000, 0001. Pushes one cycle later with matching words.
- Skip empty: fifos_empty=4'b0101 -> pop alternates 0010, 1000. Push data comes only from FIFOs 1 and 3.
- Backpressure: raise fifo_almost_full during ACTIVE -> pop=0 that cycle, the in-flight word still pushed next cycle, state=STALL. Drop it -> resumes with the next round-robin index, not repeating the last one.
- Drain/idle: last word of the last nonempty FIFO popped -> push next cycle, then idle=1. Assert reset=0 mid-stream -> push=0 immediately, pointer back to 3.
- ARB_BURST_EN with BURST_LEN=2, all nonempty -> pop sequence 0001, 0001, 0010, 0010, 0100, 0100. If FIFO 0 empties after 1 pop, the grant moves to FIFO 1 at once.
